// File: rtl/repairmb_pkg.sv
// Shared REPAIRMB definitions: sideband message codes, lane-map constants and responder states.
// Used by both the REPAIRMB initiator and responder.
package repairmb_pkg;

  localparam logic [3:0] MSG_NONE               = 4'b0000;
  localparam logic [3:0] MSG_START_REQ          = 4'b0001;
  localparam logic [3:0] MSG_START_RESP         = 4'b0010;
  localparam logic [3:0] MSG_END_REQ            = 4'b0011;
  localparam logic [3:0] MSG_END_RESP           = 4'b0100;
  localparam logic [3:0] MSG_APPLY_DEGRADE_REQ  = 4'b0101;
  localparam logic [3:0] MSG_APPLY_DEGRADE_RESP = 4'b0110;

  localparam logic [1:0] LANES_NONE = 2'b00;
  localparam logic [1:0] LANES_LO   = 2'b01;
  localparam logic [1:0] LANES_HI   = 2'b10;
  localparam logic [1:0] LANES_ALL  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_BUSY_START = 4'd2,
    ST_START_RESP = 4'd3,
    ST_WAIT_REQ   = 4'd4,
    ST_BUSY_DEG   = 4'd5,
    ST_DEG_RESP   = 4'd6,
    ST_BUSY_END   = 4'd7,
    ST_END_RESP   = 4'd8,
    ST_DONE       = 4'd9,
    ST_ERROR      = 4'd10
  } state_t;

  function automatic logic is_half_width(input logic [1:0] lanes);
    return (lanes == LANES_LO) || (lanes == LANES_HI);
  endfunction

endpackage

// File: rtl/repairmb_timeout_counter.sv
// Inactivity timer: counts while run_i is high, clears on clear_i.
// expired_o is combinational from the count; no backpressure.
module repairmb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/repairmb_partner_responder.sv
// REPAIRMB responder: answers start/apply-degrade/end requests and latches the requested lane map.
// Outputs registered from next state (1 cycle); responses wait while sideband TX is busy.
module repairmb_partner_responder
  import repairmb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_repairmb_en,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_msg_info,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOut_responder,
  output logic [2:0] o_msg_info_responder,
  output logic [1:0] o_Functional_Lanes,
  output logic       o_apply_repeater,
  output logic       o_repairmb_resp_end,
  output logic       o_error
);

  state_t     state_q, state_d;
  logic [1:0] req_lanes_q, req_lanes_d;
  logic [3:0] tx_msg_q, tx_msg_d;
  logic       tx_vld_q, tx_vld_d;
  logic [2:0] tx_info_q, tx_info_d;
  logic [1:0] lanes_q, lanes_d;
  logic       repeater_q, repeater_d;
  logic       resp_end_q, resp_end_d;
  logic       error_q, error_d;

  logic       tmo_run;
  logic       tmo_clear;
  logic       tmo_expired;
  logic [1:0] rx_lanes;
  logic       unused_info_msb;

  assign rx_lanes        = i_msg_info[1:0];
  assign unused_info_msb = i_msg_info[2];
  assign tmo_run         = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_REQ);
  assign tmo_clear       = (state_d != state_q);

  repairmb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timeout (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .run_i    (tmo_run),
    .clear_i  (tmo_clear),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_lanes_d = req_lanes_q;
    if (!i_repairmb_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT_START;
        ST_WAIT_START: begin
          if (tmo_expired) begin
            state_d = ST_ERROR;
          end else if (i_msg_valid && (i_RX_SbMessage == MSG_START_REQ)) begin
            state_d = ST_BUSY_START;
          end
        end
        ST_BUSY_START: if (!i_Busy_SideBand) state_d = ST_START_RESP;
        ST_START_RESP: if (i_falling_edge_busy) state_d = ST_WAIT_REQ;
        ST_WAIT_REQ: begin
          if (tmo_expired) begin
            state_d = ST_ERROR;
          end else if (i_msg_valid) begin
            if (i_RX_SbMessage == MSG_APPLY_DEGRADE_REQ) begin
              // An empty lane map cannot be applied; abort instead of answering.
              if (rx_lanes == LANES_NONE) begin
                state_d = ST_ERROR;
              end else begin
                state_d     = ST_BUSY_DEG;
                req_lanes_d = rx_lanes;
              end
            end else if (i_RX_SbMessage == MSG_END_REQ) begin
              state_d = ST_BUSY_END;
            end else if (i_RX_SbMessage == MSG_START_REQ) begin
              state_d = ST_BUSY_START;
            end
          end
        end
        ST_BUSY_DEG:  if (!i_Busy_SideBand) state_d = ST_DEG_RESP;
        ST_DEG_RESP:  if (i_falling_edge_busy) state_d = ST_WAIT_REQ;
        ST_BUSY_END:  if (!i_Busy_SideBand) state_d = ST_END_RESP;
        ST_END_RESP:  if (i_falling_edge_busy) state_d = ST_DONE;
        ST_DONE:      state_d = ST_DONE;
        ST_ERROR:     state_d = ST_ERROR;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_msg_d   = MSG_NONE;
    tx_vld_d   = 1'b0;
    tx_info_d  = 3'b000;
    lanes_d    = lanes_q;
    repeater_d = i_repairmb_en ? repeater_q : 1'b0;
    resp_end_d = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
    if (state_d != state_q) begin
      unique case (state_d)
        ST_START_RESP: begin
          tx_msg_d = MSG_START_RESP;
          tx_vld_d = 1'b1;
        end
        ST_DEG_RESP: begin
          tx_msg_d   = MSG_APPLY_DEGRADE_RESP;
          tx_vld_d   = 1'b1;
          tx_info_d  = {1'b0, req_lanes_q};
          lanes_d    = req_lanes_q;
          repeater_d = is_half_width(req_lanes_q);
        end
        ST_END_RESP: begin
          tx_msg_d = MSG_END_RESP;
          tx_vld_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_lanes_q <= LANES_ALL;
      tx_msg_q    <= MSG_NONE;
      tx_vld_q    <= 1'b0;
      tx_info_q   <= 3'b000;
      lanes_q     <= LANES_ALL;
      repeater_q  <= 1'b0;
      resp_end_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_lanes_q <= req_lanes_d;
      tx_msg_q    <= tx_msg_d;
      tx_vld_q    <= tx_vld_d;
      tx_info_q   <= tx_info_d;
      lanes_q     <= lanes_d;
      repeater_q  <= repeater_d;
      resp_end_q  <= resp_end_d;
      error_q     <= error_d;
    end
  end

  assign o_TX_SbMessage       = tx_msg_q;
  assign o_ValidOut_responder = tx_vld_q;
  assign o_msg_info_responder = tx_info_q;
  assign o_Functional_Lanes   = lanes_q;
  assign o_apply_repeater     = repeater_q;
  assign o_repairmb_resp_end  = resp_end_q;
  assign o_error              = error_q;

endmodule

// File: tb/tb_repairmb_partner_responder.sv
// Directed, table-driven bench for the REPAIRMB responder; each vector is one clock of stimulus
// followed by the full output set expected just after that edge.
module tb_repairmb_partner_responder;

  localparam logic [3:0] S_RQ = 4'b0001, S_RS = 4'b0010;
  localparam logic [3:0] E_RQ = 4'b0011, E_RS = 4'b0100;
  localparam logic [3:0] D_RQ = 4'b0101, D_RS = 4'b0110;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [3:0] msg;
    logic       vld;
    logic [2:0] info;
    logic       busy;
    logic       feb;
    logic [3:0] e_tx;
    logic       e_v;
    logic [2:0] e_info;
    logic [1:0] e_lanes;
    logic       e_rep;
    logic       e_end;
    logic       e_err;
  } vec_t;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] msg = 4'b0;
  logic       vld = 1'b0;
  logic [2:0] info = 3'b0;
  logic       busy = 1'b0;
  logic       feb = 1'b0;
  logic [3:0] o_tx;
  logic       o_v;
  logic [2:0] o_info;
  logic [1:0] o_lanes;
  logic       o_rep;
  logic       o_end;
  logic       o_err;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  repairmb_partner_responder #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .i_repairmb_en       (en),
    .i_RX_SbMessage      (msg),
    .i_msg_valid         (vld),
    .i_msg_info          (info),
    .i_Busy_SideBand     (busy),
    .i_falling_edge_busy (feb),
    .o_TX_SbMessage      (o_tx),
    .o_ValidOut_responder(o_v),
    .o_msg_info_responder(o_info),
    .o_Functional_Lanes  (o_lanes),
    .o_apply_repeater    (o_rep),
    .o_repairmb_resp_end (o_end),
    .o_error             (o_err)
  );

  function automatic vec_t mkv(input logic r, input logic e, input logic [3:0] m, input logic v,
                               input logic [2:0] i, input logic b, input logic f,
                               input logic [3:0] etx, input logic ev, input logic [2:0] ei,
                               input logic [1:0] el, input logic er, input logic een, input logic eer);
    vec_t t;
    t = '{r, e, m, v, i, b, f, etx, ev, ei, el, er, een, eer};
    return t;
  endfunction

  // Drive on the falling edge, compare 1 time unit after the following rising edge.
  task automatic apply(input vec_t t, input string name);
    logic [12:0] got, exp;
    @(negedge CLK);
    rst_n = t.rst_n; en = t.en; msg = t.msg; vld = t.vld;
    info = t.info; busy = t.busy; feb = t.feb;
    @(posedge CLK);
    #1;
    got = {o_tx, o_v, o_info, o_lanes, o_rep, o_end, o_err};
    exp = {t.e_tx, t.e_v, t.e_info, t.e_lanes, t.e_rep, t.e_end, t.e_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got tx=%b v=%b info=%b lanes=%b rep=%b end=%b err=%b, want tx=%b v=%b info=%b lanes=%b rep=%b end=%b err=%b",
               name, o_tx, o_v, o_info, o_lanes, o_rep, o_end, o_err,
               t.e_tx, t.e_v, t.e_info, t.e_lanes, t.e_rep, t.e_end, t.e_err);
    end
  endtask

  initial begin
    // Fields: rst en msg vld info busy feb | tx v info lanes rep end err
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0)); // reset values
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0)); // -> WAIT_START
    tbl.push_back(mkv(1,1,E_RQ,1,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0)); // end_req ignored
    tbl.push_back(mkv(1,1,S_RQ,0,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0)); // no valid, ignored
    tbl.push_back(mkv(1,1,S_RQ,1,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0)); // -> BUSY_START
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, S_RS,1,3'b000,2'b11,0,0,0)); // start_resp pulse
    tbl.push_back(mkv(1,1,0,0,3'b000,1,0, 0,0,3'b000,2'b11,0,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b11,0,0,0)); // -> WAIT_REQ
    tbl.push_back(mkv(1,1,D_RQ,1,3'b011,0,0, 0,0,3'b000,2'b11,0,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, D_RS,1,3'b011,2'b11,0,0,0)); // full width resp
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b11,0,0,0));
    tbl.push_back(mkv(1,1,D_RQ,1,3'b001,0,0, 0,0,3'b000,2'b11,0,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, D_RS,1,3'b001,2'b01,1,0,0)); // half width low
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b01,1,0,0));
    tbl.push_back(mkv(1,1,D_RQ,1,3'b011,0,0, 0,0,3'b000,2'b01,1,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, D_RS,1,3'b011,2'b11,0,0,0)); // back to full
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b11,0,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b11,0,0,0)); // stray feb ignored
    tbl.push_back(mkv(1,1,D_RQ,1,3'b110,0,0, 0,0,3'b000,2'b11,0,0,0)); // info[2] not a lane bit
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, D_RS,1,3'b010,2'b10,1,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b10,1,0,0));
    tbl.push_back(mkv(1,1,S_RQ,1,3'b000,0,0, 0,0,3'b000,2'b10,1,0,0)); // repeated start
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, S_RS,1,3'b000,2'b10,1,0,0)); // lanes kept
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b10,1,0,0));
    tbl.push_back(mkv(1,1,E_RQ,1,3'b000,1,0, 0,0,3'b000,2'b10,1,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,1,0, 0,0,3'b000,2'b10,1,0,0)); // end held by busy
    tbl.push_back(mkv(1,1,0,0,3'b000,0,0, E_RS,1,3'b000,2'b10,1,0,0));
    tbl.push_back(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b10,1,1,0)); // DONE
    tbl.push_back(mkv(1,1,S_RQ,1,3'b000,0,1, 0,0,3'b000,2'b10,1,1,0)); // DONE is sticky
    tbl.push_back(mkv(1,0,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0)); // enable drop keeps lanes

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Busy stall: start_req while TX busy for 10 cycles, exactly one pulse after release.
    apply(mkv(1,1,0,0,3'b000,1,0, 0,0,3'b000,2'b10,0,0,0), "stall_en");
    apply(mkv(1,1,S_RQ,1,3'b000,1,0, 0,0,3'b000,2'b10,0,0,0), "stall_req");
    for (int k = 0; k < 10; k++)
      apply(mkv(1,1,0,0,3'b000,1,0, 0,0,3'b000,2'b10,0,0,0), $sformatf("stall_busy%0d", k));
    apply(mkv(1,1,0,0,3'b000,0,0, S_RS,1,3'b000,2'b10,0,0,0), "stall_release");
    for (int k = 0; k < 3; k++)
      apply(mkv(1,1,0,0,3'b000,1,0, 0,0,3'b000,2'b10,0,0,0), $sformatf("stall_single%0d", k));
    apply(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b10,0,0,0), "stall_to_wait");

    // Illegal empty lane map: no response, error until enable drops.
    apply(mkv(1,1,D_RQ,1,3'b100,0,0, 0,0,3'b000,2'b10,0,0,1), "illegal_map");
    apply(mkv(1,1,D_RQ,1,3'b011,0,0, 0,0,3'b000,2'b10,0,0,1), "error_sticky");
    apply(mkv(1,0,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0), "error_clear");

    // Timeout with no request: error on the 16th edge after entering WAIT_START.
    apply(mkv(1,1,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0), "tmo_enter");
    for (int k = 1; k <= 16; k++)
      apply(mkv(1,1,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,(k == 16)), $sformatf("tmo_cycle%0d", k));
    apply(mkv(1,0,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0), "tmo_clear");

    // Reset while in DEG_RESP.
    apply(mkv(1,1,0,0,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0), "rst_seq_en");
    apply(mkv(1,1,S_RQ,1,3'b000,0,0, 0,0,3'b000,2'b10,0,0,0), "rst_seq_start");
    apply(mkv(1,1,0,0,3'b000,0,0, S_RS,1,3'b000,2'b10,0,0,0), "rst_seq_sresp");
    apply(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b10,0,0,0), "rst_seq_wait");
    apply(mkv(1,1,D_RQ,1,3'b001,0,0, 0,0,3'b000,2'b10,0,0,0), "rst_seq_deg");
    apply(mkv(1,1,0,0,3'b000,0,0, D_RS,1,3'b001,2'b01,1,0,0), "rst_seq_dresp");
    apply(mkv(0,1,0,0,3'b000,1,0, 0,0,3'b000,2'b11,0,0,0), "rst_mid_resp");
    apply(mkv(1,1,0,0,3'b000,0,1, 0,0,3'b000,2'b11,0,0,0), "rst_restart");
    apply(mkv(1,1,S_RQ,1,3'b000,0,0, 0,0,3'b000,2'b11,0,0,0), "rst_restart_req");
    apply(mkv(1,1,0,0,3'b000,0,0, S_RS,1,3'b000,2'b11,0,0,0), "rst_restart_resp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
